// File: rtl/m6502_int_ctrl.sv
// Interrupt/reset sequencer for the 6502 core: maskable IRQ channels, edge-latched NMI, BRK and reset vector.
// Optional macro IRQ_SYNC_EN adds 2-flop synchronisers on irq_src and nmi_n.
module m6502_int_ctrl #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned VECTORED     = 0,
  parameter logic [15:0] NMI_VEC      = 16'hFFFA,
  parameter logic [15:0] RST_VEC      = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC      = 16'hFFFE,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0,
  localparam int unsigned IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               rdy,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi_n,
  input  logic               i_flag,
  input  logic               brk_req,
  input  logic               poll,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               int_valid,
  output logic [1:0]         int_kind,
  output logic [15:0]        int_vec,
  output logic               int_b,
  output logic [IDW-1:0]     int_id,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam logic [1:0] KindReset = 2'd0;
  localparam logic [1:0] KindNmi   = 2'd1;
  localparam logic [1:0] KindIrq   = 2'd2;
  localparam logic [1:0] KindBrk   = 2'd3;

  typedef enum logic [1:0] {StRstPend, StIdle, StPend, StService} state_e;

  state_e r_state, w_state_d;

  logic [NUM_IRQ-1:0] w_irq_in;
  logic               w_nmi_in;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_irq_s1, r_irq_s2;
  logic               r_nmi_s1, r_nmi_s2;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
      r_nmi_s1 <= 1'b1;
      r_nmi_s2 <= 1'b1;
    end else begin
      r_irq_s1 <= irq_src;
      r_irq_s2 <= r_irq_s1;
      r_nmi_s1 <= nmi_n;
      r_nmi_s2 <= r_nmi_s1;
    end
  end

  assign w_irq_in = r_irq_s2;
  assign w_nmi_in = r_nmi_s2;
`else
  assign w_irq_in = irq_src;
  assign w_nmi_in = nmi_n;
`endif

  // Edge capture runs every cycle regardless of rdy.
  logic [NUM_IRQ-1:0] r_irq_prev, r_pend_edge, w_pend_edge_d;
  logic [NUM_IRQ-1:0] w_irq_rise, w_pend_clr, w_pend, w_eff;
  logic               r_nmi_prev, r_nmi_latch, w_nmi_fall, w_nmi_clr;
  logic               w_ack_fire, w_irq_req, w_req_any, w_load;
  logic [IDW-1:0]     w_win_id;

  logic [1:0]     r_kind, w_sel_kind;
  logic [15:0]    r_vec, w_sel_vec;
  logic           r_b, w_sel_b;
  logic [IDW-1:0] r_id, w_sel_id;

  assign w_ack_fire = rdy & int_ack & ((r_state == StPend) | (r_state == StRstPend));
  assign w_nmi_clr  = w_ack_fire & (r_kind == KindNmi);
  assign w_irq_rise = w_irq_in & ~r_irq_prev;
  assign w_nmi_fall = r_nmi_prev & ~w_nmi_in;

  always_comb begin
    w_pend_clr = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (w_ack_fire && (r_kind == KindIrq) && (r_id == IDW'(i))) w_pend_clr[i] = 1'b1;
    end
  end

  // A new edge arriving with the clear wins, so no interrupt is lost.
  assign w_pend_edge_d = ((r_pend_edge & ~w_pend_clr) | w_irq_rise) & irq_edge_mode;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_irq_prev  <= '0;
      r_pend_edge <= '0;
      r_nmi_prev  <= 1'b1;
      r_nmi_latch <= 1'b0;
    end else begin
      r_irq_prev  <= w_irq_in;
      r_pend_edge <= w_pend_edge_d;
      r_nmi_prev  <= w_nmi_in;
      r_nmi_latch <= w_nmi_fall | (r_nmi_latch & ~w_nmi_clr);
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      w_pend[i] = irq_edge_mode[i] ? r_pend_edge[i] : w_irq_in[i];
    end
  end

  assign w_eff     = w_pend & irq_mask;
  assign w_irq_req = (|w_eff) & ~i_flag;
  assign w_req_any = r_nmi_latch | brk_req | w_irq_req;

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    w_win_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (w_eff[i]) w_win_id = IDW'(i);
    end
  end

  always_comb begin
    w_sel_kind = KindIrq;
    w_sel_vec  = IRQ_VEC;
    w_sel_b    = 1'b0;
    w_sel_id   = '0;
    if (r_nmi_latch) begin
      w_sel_kind = KindNmi;
      w_sel_vec  = NMI_VEC;
    end else if (brk_req) begin
      w_sel_kind = KindBrk;
      w_sel_vec  = IRQ_VEC;
      w_sel_b    = 1'b1;
    end else begin
      w_sel_id = w_win_id;
      if (VECTORED != 0) w_sel_vec = IRQ_VEC_BASE + (16'(w_win_id) << 1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= StRstPend;
    else     r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRstPend, StPend: if (rdy && int_ack) w_state_d = StService;
      StIdle:            if (rdy && poll && w_req_any) w_state_d = StPend;
      StService:         if (rdy && int_done) w_state_d = StIdle;
      default:           w_state_d = StRstPend;
    endcase
  end

  // FSM: outputs
  always_comb begin
    int_valid = (r_state == StPend) || (r_state == StRstPend);
  end

  assign w_load = (r_state == StIdle) & rdy & poll & w_req_any;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_kind <= KindReset;
      r_vec  <= RST_VEC;
      r_b    <= 1'b0;
      r_id   <= '0;
    end else if (w_load) begin
      r_kind <= w_sel_kind;
      r_vec  <= w_sel_vec;
      r_b    <= w_sel_b;
      r_id   <= w_sel_id;
    end
  end

  assign int_kind    = r_kind;
  assign int_vec     = r_vec;
  assign int_b       = r_b;
  assign int_id      = r_id;
  assign irq_pending = w_pend;

endmodule

// File: tb/tb_m6502_int_ctrl.sv
// Directed bench for m6502_int_ctrl (NUM_IRQ=4, VECTORED=0); waits a few cycles after input changes
// so it also tolerates the synchronised build.
module tb_m6502_int_ctrl;

  logic       clk = 1'b0;
  logic       res, rdy, nmi_n, i_flag, brk_req, poll, int_ack, int_done;
  logic [3:0] irq_src, irq_edge_mode, irq_mask;
  logic       int_valid, int_b;
  logic [1:0] int_kind, int_id;
  logic [15:0] int_vec;
  logic [3:0] irq_pending;

  int errors = 0;
  int checks = 0;

  m6502_int_ctrl #(.NUM_IRQ(4), .VECTORED(0)) dut (
    .clk          (clk),
    .res          (res),
    .rdy          (rdy),
    .irq_src      (irq_src),
    .irq_edge_mode(irq_edge_mode),
    .irq_mask     (irq_mask),
    .nmi_n        (nmi_n),
    .i_flag       (i_flag),
    .brk_req      (brk_req),
    .poll         (poll),
    .int_ack      (int_ack),
    .int_done     (int_done),
    .int_valid    (int_valid),
    .int_kind     (int_kind),
    .int_vec      (int_vec),
    .int_b        (int_b),
    .int_id       (int_id),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait3();
    tick(); tick(); tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_poll(input logic brk);
    poll = 1'b1; brk_req = brk;
    tick();
    poll = 1'b0; brk_req = 1'b0;
  endtask

  task automatic ack_done();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  initial begin
    res = 1'b1; rdy = 1'b1; nmi_n = 1'b1; i_flag = 1'b0; brk_req = 1'b0; poll = 1'b0;
    int_ack = 1'b0; int_done = 1'b0; irq_src = '0; irq_edge_mode = '0; irq_mask = '0;
    tick(); tick();
    chk("rst_valid", 32'(int_valid), 32'd1);
    chk("rst_kind", 32'(int_kind), 32'd0);
    chk("rst_vec", 32'(int_vec), 32'hFFFC);
    chk("rst_b", 32'(int_b), 32'd0);
    chk("rst_id", 32'(int_id), 32'd0);
    chk("rst_pending", 32'(irq_pending), 32'd0);

    // 1: reset vector handshake
    res = 1'b0;
    tick();
    chk("t1_hold_valid", 32'(int_valid), 32'd1);
    chk("t1_hold_vec", 32'(int_vec), 32'hFFFC);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t1_ack_valid", 32'(int_valid), 32'd0);
    do_poll(1'b0);
    chk("t1_svc_poll_ignored", 32'(int_valid), 32'd0);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    do_poll(1'b0);
    chk("t1_idle_nothing", 32'(int_valid), 32'd0);

    // 2: edge-mode channel 2
    irq_edge_mode = 4'b0100; irq_mask = 4'b0100;
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    wait3();
    chk("t2_pending", 32'(irq_pending), 32'b0100);
    do_poll(1'b0);
    chk("t2_valid", 32'(int_valid), 32'd1);
    chk("t2_kind", 32'(int_kind), 32'd2);
    chk("t2_id", 32'(int_id), 32'd2);
    chk("t2_vec", 32'(int_vec), 32'hFFFE);
    chk("t2_b", 32'(int_b), 32'd0);
    irq_mask = 4'b0000;
    tick();
    chk("t2_no_rearb_valid", 32'(int_valid), 32'd1);
    chk("t2_no_rearb_id", 32'(int_id), 32'd2);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t2_ack_valid", 32'(int_valid), 32'd0);
    chk("t2_ack_clears", 32'(irq_pending), 32'd0);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;

    // 3: NMI beats BRK beats level IRQ
    irq_mask = 4'b0001; irq_src = 4'b0001;
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    wait3();
    do_poll(1'b1);
    chk("t3_nmi_kind", 32'(int_kind), 32'd1);
    chk("t3_nmi_vec", 32'(int_vec), 32'hFFFA);
    chk("t3_nmi_b", 32'(int_b), 32'd0);
    ack_done();
    do_poll(1'b1);
    chk("t3_brk_valid", 32'(int_valid), 32'd1);
    chk("t3_brk_kind", 32'(int_kind), 32'd3);
    chk("t3_brk_b", 32'(int_b), 32'd1);
    chk("t3_brk_vec", 32'(int_vec), 32'hFFFE);
    ack_done();
    do_poll(1'b0);
    chk("t3_irq_kind", 32'(int_kind), 32'd2);
    chk("t3_irq_id", 32'(int_id), 32'd0);
    chk("t3_irq_b", 32'(int_b), 32'd0);
    ack_done();

    // 4: I flag blocks IRQ
    i_flag = 1'b1;
    do_poll(1'b0);
    chk("t4_iflag_blocks", 32'(int_valid), 32'd0);
    i_flag = 1'b0;
    do_poll(1'b0);
    chk("t4_iflag_clear_valid", 32'(int_valid), 32'd1);
    chk("t4_iflag_clear_kind", 32'(int_kind), 32'd2);
    ack_done();
    irq_src = 4'b0000;

    // 5: new edge coincident with clear survives
    irq_edge_mode = 4'b0010; irq_mask = 4'b0010;
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0000;
    wait3();
    do_poll(1'b0);
    chk("t5_first_id", 32'(int_id), 32'd1);
    int_ack = 1'b1; irq_src = 4'b0010;
    tick();
    int_ack = 1'b0; irq_src = 4'b0000;
    wait3();
    chk("t5_ack_valid", 32'(int_valid), 32'd0);
    chk("t5_set_wins", 32'(irq_pending), 32'b0010);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    do_poll(1'b0);
    chk("t5_again_valid", 32'(int_valid), 32'd1);
    chk("t5_again_id", 32'(int_id), 32'd1);
    ack_done();
    chk("t5_cleared", 32'(irq_pending), 32'd0);

    // Lowest channel wins among several
    irq_edge_mode = 4'b1111; irq_mask = 4'b1010;
    irq_src = 4'b1010;
    tick();
    irq_src = 4'b0000;
    wait3();
    chk("prio_pending", 32'(irq_pending), 32'b1010);
    do_poll(1'b0);
    chk("prio_first_id", 32'(int_id), 32'd1);
    ack_done();
    chk("prio_after_clear", 32'(irq_pending), 32'b1000);
    do_poll(1'b0);
    chk("prio_second_id", 32'(int_id), 32'd3);
    ack_done();

    // 6: rdy stall and reset mid-service
    do_poll(1'b1);
    chk("t6_brk_valid", 32'(int_valid), 32'd1);
    rdy = 1'b0; int_ack = 1'b1; int_done = 1'b1;
    tick(); tick();
    chk("t6_stall_valid", 32'(int_valid), 32'd1);
    chk("t6_stall_kind", 32'(int_kind), 32'd3);
    rdy = 1'b1; int_done = 1'b0;
    tick();
    int_ack = 1'b0;
    chk("t6_ack_after_rdy", 32'(int_valid), 32'd0);
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    wait3();
    chk("t6_pend_before_rst", 32'(irq_pending), 32'b0100);
    res = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(int_valid), 32'd1);
    chk("t6_rst_kind", 32'(int_kind), 32'd0);
    chk("t6_rst_vec", 32'(int_vec), 32'hFFFC);
    chk("t6_rst_b", 32'(int_b), 32'd0);
    chk("t6_rst_pending", 32'(irq_pending), 32'd0);
    res = 1'b0;
    tick();
    chk("t6_post_rst_valid", 32'(int_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
